// File: rtl/mvm_pkg.sv
// Shared types and default sizes for the mvm stream controller.
//   op_t    : command opcodes carried on cmd_op
//   state_t : controller FSM states
package mvm_pkg;

    localparam int M_DEF       = 8;     // matrix dimension
    localparam int W_DEF       = 16;    // operand width
    localparam int TIMEOUT_DEF = 1024;  // start-to-done cycle limit

    typedef enum logic [1:0] {
        OP_LOAD_MAT,
        OP_LOAD_VEC,
        OP_COMPUTE,
        OP_ILLEGAL
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_BURST,
        ST_WAIT_DONE,
        ST_CAPTURE
    } state_t;

endpackage

// File: rtl/mvm_stream_ctrl_if.sv
// Upstream/downstream stream bundle for mvm_stream_ctrl.
//   cmd_*  : command stream (op code)
//   s_*    : operand word stream, W bits signed
//   m_*    : result stream, 2W bits signed, m_last on the final word
//   err_*  : error indications from the controller
// Modports: master = producer/consumer side, slave = controller side.
interface mvm_stream_ctrl_if #(parameter int W = mvm_pkg::W_DEF);
    import mvm_pkg::*;

    logic           cmd_valid;
    logic           cmd_ready;
    op_t            cmd_op;

    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;

    logic           m_valid;
    logic           m_ready;
    logic [2*W-1:0] m_data;
    logic           m_last;

    logic           err_illegal;
    logic           err_timeout;

    modport master (
        output cmd_valid, cmd_op, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_data, m_last, err_illegal, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_data, m_last, err_illegal, err_timeout
    );

endinterface

// File: rtl/mvm_result_fifo.sv
// Synchronous FIFO holding core results together with a last tag.
//   push_i/din_i/last_i : write side, ignored when full
//   pop_i               : read side, ignored when empty
//   dout_o/last_o       : head entry, valid while !empty_o
//   full_o/empty_o      : occupancy flags
module mvm_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             last_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             last_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign {last_o, dout_o} = mem_q[rd_q];

    // Pointer wrap without relying on DEPTH being a power of two.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= {last_i, din_i};
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mvm_stream_ctrl.sv
// Stream controller for the mvm_<M>_1_<W>_1 matrix-vector core.
// Operand words arrive with arbitrary gaps and are staged, then replayed to
// the core as one gap-free load burst. After start, the M results that
// follow done are captured into a FIFO and returned on the m_* stream.
//   clk, reset      : single clock, synchronous active-high reset
//   bus (slave)     : cmd/s/m streams and error flags
//   mvm_loadMatrix, mvm_loadVector, mvm_start : one-cycle pulses to core
//   mvm_data_in     : operand to core, zero outside bursts
//   mvm_done        : core done
//   mvm_data_out    : core result, one per cycle for M cycles after done
module mvm_stream_ctrl
    import mvm_pkg::*;
#(
    parameter int M       = M_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mvm_stream_ctrl_if.slave bus,
    output logic           mvm_loadMatrix,
    output logic           mvm_loadVector,
    output logic           mvm_start,
    output logic [W-1:0]   mvm_data_in,
    input  logic           mvm_done,
    input  logic [2*W-1:0] mvm_data_out
);

    localparam int N_MAT = M * M;
    localparam int CNT_W = $clog2(N_MAT + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int AW    = (N_MAT > 1) ? $clog2(N_MAT) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              is_mat_q, is_mat_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              start_q, start_d;
    logic              illegal_q, illegal_d;
    logic              tout_q, tout_d;

    logic [W-1:0]      stage_q [N_MAT];
    logic [AW-1:0]     wr_idx, rd_idx;

    logic              cmd_fire, s_fire;
    logic              fifo_push, fifo_pop, push_last;
    logic              fifo_full, fifo_empty;

    assign bus.cmd_ready   = (state_q == ST_IDLE) && fifo_empty;
    assign bus.s_ready     = (state_q == ST_FILL);
    assign bus.m_valid     = !fifo_empty;
    assign bus.err_illegal = illegal_q;
    assign bus.err_timeout = tout_q;
    assign mvm_start       = start_q;

    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign s_fire   = bus.s_valid && bus.s_ready;
    assign fifo_pop = bus.m_valid && bus.m_ready;

    // During FILL cnt_q is the next write slot; during BURST cycle k>0
    // replays slot k-1 (cycle 0 carries the load strobe).
    assign wr_idx = AW'(cnt_q);
    assign rd_idx = AW'(cnt_q - 1'b1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        is_mat_d       = is_mat_q;
        tmr_d          = tmr_q;
        start_d        = 1'b0;
        illegal_d      = 1'b0;
        tout_d         = tout_q;
        fifo_push      = 1'b0;
        push_last      = 1'b0;
        mvm_loadMatrix = 1'b0;
        mvm_loadVector = 1'b0;
        mvm_data_in    = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (bus.cmd_op)
                        OP_LOAD_MAT: begin
                            state_d  = ST_FILL;
                            len_d    = CNT_W'(N_MAT);
                            is_mat_d = 1'b1;
                            cnt_d    = '0;
                        end
                        OP_LOAD_VEC: begin
                            state_d  = ST_FILL;
                            len_d    = CNT_W'(M);
                            is_mat_d = 1'b0;
                            cnt_d    = '0;
                        end
                        OP_COMPUTE: begin
                            state_d = ST_WAIT_DONE;
                            start_d = 1'b1;
                            tmr_d   = '0;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end

            ST_FILL: begin
                if (s_fire) begin
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_BURST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_BURST: begin
                if (cnt_q == '0) begin
                    mvm_loadMatrix = is_mat_q;
                    mvm_loadVector = !is_mat_q;
                end else begin
                    mvm_data_in = stage_q[rd_idx];
                end
                if (cnt_q == len_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (mvm_done) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_CAPTURE: begin
                // FIFO is empty on entry (cmd_ready gates COMPUTE), so it
                // always has room for all M results.
                fifo_push = !fifo_full;
                push_last = (cnt_q == CNT_W'(M - 1));
                if (push_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            is_mat_q  <= 1'b0;
            tmr_q     <= '0;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            is_mat_q  <= is_mat_d;
            tmr_q     <= tmr_d;
            start_q   <= start_d;
            illegal_q <= illegal_d;
            tout_q    <= tout_d;
        end
    end

    // Staging RAM shared by matrix and vector loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_MAT; i++) stage_q[i] <= '0;
        end else if (s_fire) begin
            stage_q[wr_idx] <= bus.s_data;
        end
    end

    mvm_result_fifo #(
        .DEPTH (M),
        .WIDTH (2 * W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (mvm_data_out),
        .last_i  (push_last),
        .pop_i   (fifo_pop),
        .dout_o  (bus.m_data),
        .last_o  (bus.m_last),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
